// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
// Holds the FSM state encoding, the width limits and the width helpers.
// Imported by the sequencer top. The full-adder cell has no parameters and does not need it.
package serial_adder_ctrl_pkg;

  // Sequencer states. The encodings are fixed so that state dumps read the same across builds.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Supported operand widths. Above 64 the result no longer fits a normal software word.
  localparam int unsigned W_MIN = 1;
  localparam int unsigned W_MAX = 64;

  // Legality check on the operand width. Used at elaboration to reject bad builds.
  function automatic bit w_is_legal(input int unsigned w);
    return (w >= W_MIN) && (w <= W_MAX);
  endfunction

  // Bit-counter width. It is at least 1, so W=1 still gets a real counter bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// Single-bit full adder. This is the per-bit datapath cell reused once per cycle by the sequencer.
// Latency: purely combinational.
// Backpressure: none. The outputs follow the inputs.
module serial_adder_ctrl_fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  logic p;

  // A propagate term is shared between the sum and the carry.
  assign p    = a_i ^ b_i;
  assign s_o  = p ^ c_i;
  assign co_o = (a_i & b_i) | (c_i & p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell adds two W-bit operands plus a carry-in, LSB first, over W cycles.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+W; one op per W+2 cycles.
// Backpressure: start is only sampled while ready=1. Starts in RUN/DONE are dropped without effect.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int CW = int'(cnt_width(W));
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  // Refuse to elaborate with an unsupported operand width.
  if (!w_is_legal(W)) begin : g_w_illegal
    $error("serial_adder_ctrl: W=%0d outside supported range 1..64", W);
  end

  state_e        state_q, state_d;

  // Operand shift registers. Bit 0 always holds the bit currently being added.
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  // Partial sum. Each new bit enters at the MSB, so after W steps it is in place.
  logic [W-1:0]  sum_sh_q, sum_sh_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Visible results. They change only when a completed operation enters DONE.
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic          fa_s;
  logic          fa_co;
  logic          last_step;

  serial_adder_ctrl_fulladder u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .c_i  (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  assign last_step = (cnt_q == CNT_LAST);

  // State register. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: IDLE waits for start, RUN counts W bit steps, DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are decoded from the state alone, so reset clears them immediately.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // Datapath next-state: capture on an accepted start, then one bit step per RUN cycle.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a_in;
          b_sh_d   = b_in;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
        end
      end
      RUN: begin
        a_sh_d          = a_sh_q >> 1;
        b_sh_d          = b_sh_q >> 1;
        sum_sh_d        = sum_sh_q >> 1;
        sum_sh_d[W-1]   = fa_s;
        carry_d         = fa_co;
        cnt_d           = cnt_q + CW'(1);
        if (last_step) begin
          // On the MSB step carry_q is the carry into the MSB. Signed overflow is that carry XOR the carry out.
          sum_d  = sum_sh_d;
          cout_d = fa_co;
          ovf_d  = carry_q ^ fa_co;
        end
      end
      default: begin
        a_sh_d = a_sh_q;
      end
    endcase
  end

  // Datapath and result registers. All of them clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at W=8 (table plus corner sequences) and W=1 (truth table).
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start8, cin8, ready8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  logic       start1, cin1, ready1, busy1, done1, cout1, ovf1;
  logic [0:0] a1, b1, sum1;

  serial_adder_ctrl #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder_ctrl #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t tbl[8];

  // Issue one W=8 operation and wait for done.
  // When scramble is set, the operands change and start is held every cycle while the operation runs.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit scramble,
                         input string tag, output logic [7:0] s, output logic co, output logic ov);
    bit         seen;
    bit         moved;
    int         lat;
    logic [7:0] held;
    @(negedge clk);
    check({tag, " ready_before"}, ready8, 1);
    held   = sum8;
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    check({tag, " busy"}, busy8, 1);
    seen = 1'b0; moved = 1'b0; lat = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      if (done8) begin
        seen = 1'b1;
        lat  = i;
      end else begin
        if (sum8 !== held) moved = 1'b1;
        if (scramble) begin
          start8 = 1'b1;
          a8     = 8'($urandom);
          b8     = 8'($urandom);
          cin8   = 1'($urandom);
        end
      end
    end
    start8 = 1'b0;
    s = sum8; co = cout8; ov = ovf8;
    check({tag, " done_seen"}, seen, 1);
    check({tag, " latency"}, lat, 8);
    check({tag, " sum_stable_in_run"}, moved, 0);
    @(negedge clk);
    check({tag, " done_one_cycle"}, done8, 0);
    check({tag, " ready_back"}, ready8, 1);
  endtask

  initial begin
    logic [7:0] s;
    logic       co, ov;
    int         extra;

    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h55, 8'h2A, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    tbl[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #3;
    check("reset ready8", ready8, 1);
    check("reset busy8", busy8, 0);
    check("reset done8", done8, 0);
    check("reset sum8", sum8, 0);
    check("reset cout8/ovf8", {cout8, ovf8}, 0);
    check("reset ready1/busy1/done1", {ready1, busy1, done1}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven W=8 operations.
    for (int i = 0; i < 8; i++) begin
      run_op8(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, $sformatf("vec%0d", i), s, co, ov);
      check($sformatf("vec%0d sum", i), s, tbl[i].sum);
      check($sformatf("vec%0d cout", i), co, tbl[i].cout);
      check($sformatf("vec%0d ovf", i), ov, tbl[i].ovf);
    end

    // Reset mid-RUN at cnt=3. The result held from vec7 (0xFF, cout=1) must clear at once.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("abort busy_before", busy8, 1);
    rst_n = 1'b0;
    #1;
    check("abort ready", ready8, 1);
    check("abort busy", busy8, 0);
    check("abort done", done8, 0);
    check("abort sum", sum8, 0);
    check("abort cout/ovf", {cout8, ovf8}, 0);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) extra++;
    end
    check("abort no_done", extra, 0);
    run_op8(8'h12, 8'h34, 1'b0, 1'b0, "post_abort", s, co, ov);
    check("post_abort sum", s, 8'h46);
    check("post_abort cout/ovf", {co, ov}, 2'b00);

    // Start spammed and operands changed every RUN/DONE cycle: only the captured operands count.
    run_op8(8'hA5, 8'h5A, 1'b1, 1'b1, "spam", s, co, ov);
    check("spam sum", s, 8'h00);
    check("spam cout/ovf", {co, ov}, 2'b10);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) extra++;
    end
    check("spam no_extra_done", extra, 0);
    run_op8(8'h7F, 8'h01, 1'b0, 1'b1, "spam2", s, co, ov);
    check("spam2 sum/cout/ovf", {s, co, ov}, {8'h80, 1'b0, 1'b1});

    // W=1: the full-adder truth table, with done in the cycle after the single RUN step.
    for (int v = 0; v < 8; v++) begin
      logic ea, eb, ec, es, eco;
      bit   seen1;
      int   lat1;
      ea = v[2]; eb = v[1]; ec = v[0];
      es  = ea ^ eb ^ ec;
      eco = (ea & eb) | (ea & ec) | (eb & ec);
      @(negedge clk);
      check($sformatf("w1 v%0d ready", v), ready1, 1);
      start1 = 1'b1; a1 = ea; b1 = eb; cin1 = ec;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      seen1 = 1'b0; lat1 = -1;
      for (int i = 0; i < 10 && !seen1; i++) begin
        if (i > 0) @(negedge clk);
        if (done1) begin
          seen1 = 1'b1;
          lat1  = i;
        end
      end
      check($sformatf("w1 v%0d latency", v), lat1, 1);
      check($sformatf("w1 v%0d sum", v), sum1, es);
      check($sformatf("w1 v%0d cout", v), cout1, eco);
      check($sformatf("w1 v%0d ovf", v), ovf1, ec ^ eco);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder sequencer. It reuses one full-adder cell over W clock cycles to add two W-bit operands plus a carry-in, LSB first. It holds the running carry in a register, shifts the operands and the sum, and reports completion with a start/done handshake. It is the sequencing layer over the team's existing fulladder cell, trading area for latency in the arithmetic datapath.

Parameters:
W, 8, operand/result width in bits; legal range 1..64.
CW, derived ($clog2(W), minimum 1), bit-counter width; not overridable.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when ready=1.
a_in  input  W  operand A; captured on an accepted start.
b_in  input  W  operand B; captured on an accepted start.
cin  input  1  carry-in; captured on an accepted start.
ready  output  1  high in IDLE only.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; result valid.
sum  output  W  result; held until the next completion.
cout  output  1  carry-out of the MSB; held.
ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB); held.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all internal registers clear.
  - sum, cout and ovf clear; ready=1, busy=0, done=0.
  - Exit is synchronous to the first clk edge with rst_n=1.
- FSM:
  - IDLE: if start, capture a_in, b_in and cin into the shift registers and the carry register; clear bit counter; go to RUN. Otherwise stay.
  - RUN: the fulladder inputs are a_sh[0], b_sh[0] and carry_q. Each edge:
    - sum bit shifts into sum_sh at the MSB end;
    - a_sh and b_sh shift right;
    - carry_q takes the fulladder carry-out;
    - cnt increments.
  - RUN exit: on the edge where cnt==W-1:
    - load sum/cout/ovf from the completed shift value and the final carry;
    - go to DONE.
  - RUN capture: on the edge where cnt==W-1 (the MSB step), the carry into the MSB is carry_q before the update; latch it for ovf.
  - DONE: done=1 for exactly this cycle; go to IDLE unconditionally.
- Latency: start accepted at edge k; done high in the cycle after edge k+W; next start is accepted at edge k+W+2 at the earliest. Throughput is 1 op per W+2 cycles.
- Start outside IDLE (RUN or DONE) is ignored entirely. Operand inputs may change freely after capture.
- Result registers update only on entry to DONE. Intermediate shift contents never appear on sum.
- W=1: RUN lasts one cycle and ovf = cin XOR cout.
- All arithmetic is unsigned modulo 2^W; cout is the 2^W bit.
- Reset asserted mid-RUN: the operation aborts and no done is produced. Outputs return to reset values immediately, without waiting for clk.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), and the W legality check macro.
- One sub-module instance: the existing fulladder cell as the per-bit datapath.
- Counter, shift registers and FSM stay inline in serial_adder_ctrl.

Test Plan:
- W=8, a=0x00, b=0x00, cin=0 -> after 9 cycles done=1; sum=0x00, cout=0, ovf=0; ready returns 1 the next cycle.
- W=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
- W=8, a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1, ovf=0. Change a_in/b_in during RUN -> result unchanged.
- W=8, start pulsed in every RUN/DONE cycle with different operands -> exactly one done per accepted start; results match only the captured operands.
- W=8, rst_n low for 1 ns mid-RUN (cnt=3) -> done never pulses; sum/cout/ovf=0 and ready=1 immediately. A following 0x12+0x34 gives sum=0x46.
- W=1, all 8 (a,b,cin) combinations -> sum/cout reproduce the full-adder truth table; done 2 cycles after each accepted start.
